// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_pkg                                                      |
// | Description : Mode encodings and bounce/breathe direction constants.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package led_pkg;

   typedef enum logic [1:0] {
      MODE_BIN     = 2'd0,
      MODE_GRAY    = 2'd1,
      MODE_BOUNCE  = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_pattern_gen_if                                           |
// | Description : Control/status bundle of the LED pattern generator.          |
// |               LED_SPEED_SEL_EN adds the speed_i select.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface led_pattern_gen_if
   import led_pkg::*;
#(
   parameter int N_LEDS = 8
) ();

   led_mode_t         mode_i;
   logic              hold_i;
   logic              tick_o;
   logic [N_LEDS-1:0] leds_o;
`ifdef LED_SPEED_SEL_EN
   logic [1:0]        speed_i;

   modport master (output mode_i, hold_i, speed_i, input tick_o, leds_o);
   modport slave  (input mode_i, hold_i, speed_i, output tick_o, leds_o);
`else
   modport master (output mode_i, hold_i, input tick_o, leds_o);
   modport slave  (input mode_i, hold_i, output tick_o, leds_o);
`endif

endinterface
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_prescaler                                                |
// | Description : Free-running prescaler with registered one-cycle wrap tick.  |
// |               LED_SPEED_SEL_EN selects a narrower wrap width by i_speed.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module led_prescaler #(
   parameter int PRESCALE_BITS = 21
) (
   input  wire logic       clk,
   input  wire logic       resetn,
`ifdef LED_SPEED_SEL_EN
   input  wire logic [1:0] i_speed,
`endif
   output logic            o_tick
);

   localparam logic [PRESCALE_BITS-1:0] c_ONE = 1;

   logic [PRESCALE_BITS-1:0] r_cnt;
   logic                     w_wrap;

`ifdef LED_SPEED_SEL_EN
   logic [1:0]               r_speed;
   logic [PRESCALE_BITS-1:0] w_mask;

   function automatic logic [PRESCALE_BITS-1:0] sel_mask(input logic [1:0] s);
      int w;
      w = PRESCALE_BITS - 2 * int'(s);
      if (w < 1) w = 1;
      for (int i = 0; i < PRESCALE_BITS; i++) sel_mask[i] = (i < w);
   endfunction

   assign w_mask = sel_mask(r_speed);
   assign w_wrap = ((r_cnt & w_mask) == w_mask);

   // The active speed only changes on a wrap, so a narrower width cannot glitch.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_speed <= 2'd0;
      else if (w_wrap) r_speed <= i_speed;
   end
`else
   assign w_wrap = &r_cnt;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt  <= '0;
         o_tick <= 1'b0;
      end else begin
         r_cnt  <= r_cnt + c_ONE;
         o_tick <= w_wrap;
      end
   end

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_pattern_gen                                              |
// | Description : Prescaled multi-mode LED pattern engine (BIN/GRAY/BOUNCE/    |
// |               BREATHE). Optional speed select via LED_SPEED_SEL_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int N_LEDS        = 8,
   parameter int PRESCALE_BITS = 21,
   parameter int PWM_BITS      = 6,
   parameter int ACTIVE_LOW    = 1
) (
   input  wire logic clk,
   input  wire logic resetn,
   led_pattern_gen_if.slave bus
);

   localparam logic [N_LEDS-1:0]   c_ONE      = 1;
   localparam logic [N_LEDS-1:0]   c_POL      = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [PWM_BITS-1:0] c_PWM_ONE  = 1;
   localparam logic [PWM_BITS-1:0] c_DUTY_MAX = '1;

   logic [N_LEDS-1:0]   r_count;
   logic [N_LEDS-1:0]   r_pos;
   logic                r_dir;
   logic [PWM_BITS-1:0] r_duty;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   led_mode_t           r_mode_q;
   logic [N_LEDS-1:0]   r_leds;

   logic                w_tick;
   logic                w_mode_chg;
   logic                w_adv;
   logic [N_LEDS-1:0]   w_pattern;

   led_prescaler #(
      .PRESCALE_BITS (PRESCALE_BITS)
   ) u_prescaler (
      .clk     (clk),
      .resetn  (resetn),
`ifdef LED_SPEED_SEL_EN
      .i_speed (bus.speed_i),
`endif
      .o_tick  (w_tick)
   );

   assign w_mode_chg = (bus.mode_i != r_mode_q);
   assign w_adv      = w_tick & ~bus.hold_i & ~w_mode_chg;

   always_comb begin
      w_pattern = '0;
      case (r_mode_q)
         MODE_BIN:    w_pattern = r_count;
         MODE_GRAY:   w_pattern = r_count ^ (r_count >> 1);
         MODE_BOUNCE: w_pattern = r_pos;
         default:     w_pattern = (r_pwm_cnt < r_duty) ? '1 : '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count   <= '0;
         r_pos     <= c_ONE;
         r_dir     <= DIR_UP;
         r_duty    <= '0;
         r_pwm_cnt <= '0;
         r_mode_q  <= MODE_BIN;
         r_leds    <= c_POL;
      end else begin
         r_mode_q  <= bus.mode_i;
         r_pwm_cnt <= r_pwm_cnt + c_PWM_ONE;
         r_leds    <= w_pattern ^ c_POL;
         if (w_mode_chg) begin
            r_count <= '0;
            r_pos   <= c_ONE;
            r_dir   <= DIR_UP;
            r_duty  <= '0;
         end else if (w_adv) begin
            case (r_mode_q)
               MODE_BIN, MODE_GRAY: r_count <= r_count + c_ONE;
               MODE_BOUNCE: begin
                  // Direction flips on the same advance that leaves an end,
                  // so each end position is shown for a single tick.
                  if (N_LEDS > 1) begin
                     if (r_dir == DIR_UP) begin
                        if (r_pos[N_LEDS-1]) begin
                           r_dir <= DIR_DOWN;
                           r_pos <= r_pos >> 1;
                        end else begin
                           r_pos <= r_pos << 1;
                        end
                     end else begin
                        if (r_pos[0]) begin
                           r_dir <= DIR_UP;
                           r_pos <= r_pos << 1;
                        end else begin
                           r_pos <= r_pos >> 1;
                        end
                     end
                  end
               end
               default: begin
                  if (r_dir == DIR_UP) begin
                     if (r_duty == c_DUTY_MAX) begin
                        r_dir  <= DIR_DOWN;
                        r_duty <= r_duty - c_PWM_ONE;
                     end else begin
                        r_duty <= r_duty + c_PWM_ONE;
                     end
                  end else begin
                     if (r_duty == '0) begin
                        r_dir  <= DIR_UP;
                        r_duty <= r_duty + c_PWM_ONE;
                     end else begin
                        r_duty <= r_duty - c_PWM_ONE;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.tick_o = w_tick;
   assign bus.leds_o = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_led_pattern_gen                                           |
// | Description : Directed self-checking bench for led_pattern_gen.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_led_pattern_gen;
   import led_pkg::*;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   led_pattern_gen_if #(.N_LEDS(4)) u_if ();

   led_pattern_gen #(
      .N_LEDS        (4),
      .PRESCALE_BITS (3),
      .PWM_BITS      (2),
      .ACTIVE_LOW    (0)
   ) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (u_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns the number of falling edges walked until tick_o was seen high.
   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (u_if.tick_o !== 1'b1 && cyc < 20);
      if (cyc >= 20) check("tick_timeout", 32'd0, 32'd1);
   endtask

   // Waits for a tick, then two cycles for state advance plus output register.
   task automatic step(output logic [3:0] v, output int cyc);
      wait_tick(cyc);
      @(negedge clk);
      @(negedge clk);
      v = u_if.leds_o;
   endtask

   logic [3:0] gray_exp [16] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                                 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
   logic [3:0] bnc_exp  [7]  = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2};
   int         duty_exp [7]  = '{1, 2, 3, 2, 1, 0, 1};

   initial begin
      logic [3:0] v;
      int         c;
      int         lit;

      u_if.mode_i = MODE_BIN;
      u_if.hold_i = 1'b0;
`ifdef LED_SPEED_SEL_EN
      u_if.speed_i = 2'd0;
`endif
      repeat (3) @(negedge clk);
      check("reset_leds", 32'(u_if.leds_o), 32'd0);
      check("reset_tick", 32'(u_if.tick_o), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_leds", 32'(u_if.leds_o), 32'd0);

      // BIN: first tick 8 cycles after release, then one step per tick.
      wait_tick(c);
      check("first_tick_delay", 32'(c + 1), 32'd8);
      @(negedge clk);
      @(negedge clk);
      check("bin_1", 32'(u_if.leds_o), 32'd1);
      for (int i = 2; i <= 16; i++) begin
         step(v, c);
         check("bin_step", 32'(v), 32'(i % 16));
         check("tick_period", 32'(c + 2), 32'd8);
      end

      // GRAY from a reloaded count.
      u_if.mode_i = MODE_GRAY;
      for (int i = 0; i < 16; i++) begin
         step(v, c);
         check("gray_step", 32'(v), 32'(gray_exp[i]));
      end

      // BOUNCE.
      u_if.mode_i = MODE_BOUNCE;
      @(negedge clk);
      @(negedge clk);
      check("bounce_init", 32'(u_if.leds_o), 32'd1);
      for (int i = 0; i < 7; i++) begin
         step(v, c);
         check("bounce_step", 32'(v), 32'(bnc_exp[i]));
      end

      // BREATHE: lit cycles per 4-cycle PWM period equal the duty.
      u_if.mode_i = MODE_BREATHE;
      for (int i = 0; i < 7; i++) begin
         wait_tick(c);
         @(negedge clk);
         @(negedge clk);
         lit = 0;
         for (int k = 0; k < 4; k++) begin
            if (u_if.leds_o === 4'hF) lit++;
            else if (u_if.leds_o !== 4'h0) check("breathe_level", 32'(u_if.leds_o), 32'hF);
            @(negedge clk);
         end
         check("breathe_duty", 32'(lit), 32'(duty_exp[i]));
      end

      // Mode change on the tick cycle: reload wins over advance.
      u_if.mode_i = MODE_BIN;
      for (int i = 1; i <= 5; i++) step(v, c);
      check("bin_at_5", 32'(v), 32'd5);
      wait_tick(c);
      u_if.mode_i = MODE_GRAY;
      @(negedge clk);
      @(negedge clk);
      check("collide_reload", 32'(u_if.leds_o), 32'd0);
      step(v, c);
      check("collide_next", 32'(v), 32'd1);

      // Hold freezes the pattern while ticks continue.
      u_if.hold_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(v, c);
         check("hold_tick_period", 32'(c + 2), 32'd8);
         check("hold_leds", 32'(v), 32'd1);
      end
      u_if.hold_i = 1'b0;
      step(v, c);
      check("hold_release", 32'(v), 32'd3);

      // Asynchronous reset in the middle of BOUNCE.
      u_if.mode_i = MODE_BOUNCE;
      step(v, c);
      step(v, c);
      check("bounce_pre_reset", 32'(v), 32'd4);
      #2 resetn = 1'b0;
      #1;
      check("async_reset_leds", 32'(u_if.leds_o), 32'd0);
      check("async_reset_tick", 32'(u_if.tick_o), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("post_reset_bounce", 32'(u_if.leds_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
